gobou_fc_engine: RTL
====================

// Module: gobou_fc_engine
// PURPOSE
//  Fully-connected layer engine: y[o] = sat(relu?(sum_i w[o][i]*x[i] + b[o])).
//  CORE parallel MAC lanes; bias add, rounding, saturation; serialized write-back.
//  Image memory is external and shared for reads and writes; per-lane weight banks are external.
// PARAMETERS
//  DWIDTH   16  data/weight/bias width, signed fixed point
//  FRAC     8   fractional bits of data and weights
//  ACCWIDTH 40  accumulator width (>= 2*DWIDTH)
//  LWIDTH   10  width of total_in / total_out
//  CORE     16  parallel output lanes (>= 2)
//  IMGSIZE  12  image memory address width
//  NETSIZE  14  weight bank address width
// PORTS
//  clk            in   1               clock
//  rst            in   1               synchronous reset, active-high
//  req            in   1               start pulse, sampled only when ack=1
//  total_out      in   LWIDTH          output neuron count, sampled with req
//  total_in       in   LWIDTH          input neuron count, sampled with req
//  input_addr     in   IMGSIZE         base address of x in image memory
//  output_addr    in   IMGSIZE         base address of y in image memory
//  ack            out  1               1 = idle/done, 0 = busy
//  mem_img_we     out  1               image memory write enable
//  mem_img_addr   out  IMGSIZE         image memory address
//  write_mem_img  out  DWIDTH          image memory write data
//  read_img       in   DWIDTH          image memory read data, 1-cycle latency
//  mem_net_addr   out  NETSIZE         address broadcast to all weight banks
//  read_net       in   CORE*DWIDTH     bank k at [k*DWIDTH +: DWIDTH], 1-cycle latency
// BEHAVIOUR
//  Reset: ack=1, mem_img_we=0, all addresses 0, write_mem_img=0, accumulators 0, state IDLE.
//  rst mid-operation aborts the job; no further writes.
//  Weight layout per bank, block b: addr b*(total_in+1)+i = w[b*CORE+k][i]; addr b*(total_in+1)+total_in = bias.
//  Blocks: B = ceil(total_out/CORE); block b owns outputs b*CORE..b*CORE+n_b-1, n_b = min(CORE, total_out-b*CORE).
//  FSM: IDLE -> MAC -> BIAS -> FLUSH -> WRITE -> (MAC next block | DONE) -> IDLE.
//   IDLE : ack=1; req=1 latches inputs, ack=0 next cycle. total_out=0 -> DONE directly.
//   MAC  : total_in cycles, issue mem_img_addr=input_addr+i, mem_net_addr=base+i.
//   BIAS : 1 cycle, issue bias address. FLUSH: 2 cycles (read + multiply pipe).
//   WRITE: n_b cycles, mem_img_we=1, addr=output_addr+b*CORE+k, data=lane k result.
//   DONE : 1 cycle, then ack=1 in IDLE; ack stays 1 until next req.
//  Latency req->ack: 2 + sum_b(total_in+3+n_b) cycles.
//  req while ack=0 is ignored. total_in=0: MAC skipped, result = bias only.
//  Arithmetic: product signed 2*DWIDTH, sign-extended, accumulated in ACCWIDTH, wraps (no acc saturation).
//   r = (acc + (bias<<<FRAC) + (1<<<(FRAC-1))) >>> FRAC; saturate to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
//   Accumulators cleared at start of every block. Lanes k >= n_b compute but never write.
//  Address arithmetic wraps modulo 2^IMGSIZE / 2^NETSIZE; region overlap is caller's responsibility.
// CONFIGURATION
//  GOBOU_RELU_EN defined: after saturation, negative r written as 0.
//  GOBOU_RELU_EN undefined: saturated r written unchanged; no ReLU logic present.
// TESTING
//  Reset: rst=1 two cycles -> ack=1, mem_img_we=0, all addresses 0.
//  CORE=16, total_in=4, total_out=16, x=1.0(256), w=0.5(128), b=0 -> all 16 y=2.0(512); ack after 25 cycles.
//  total_out=20 -> two blocks; second block writes exactly 4 words at output_addr+16..19; 20 writes total.
//  Saturation: x=w=127.0, total_in=8 -> y=0x7FFF; x=-127.0, w=127.0 -> 0x8000 (0 with GOBOU_RELU_EN).
//  Edges: total_in=0, bias=-3.0 -> y=-768 (0 with RELU); total_out=0 -> no writes, ack back in 2 cycles.
//  req during busy ignored; rst asserted mid-MAC -> ack=1 next cycle, no further mem_img_we.

Source files
------------

// File: rtl/gobou_fc_engine.sv
// Fully-connected layer engine: CORE parallel MAC lanes, bias/round/saturate, serialized write-back.
// Optional build macro GOBOU_RELU_EN clamps negative results to zero before write-back.
module gobou_fc_engine #(
   parameter int DWIDTH   = 16,
   parameter int FRAC     = 8,
   parameter int ACCWIDTH = 40,
   parameter int LWIDTH   = 10,
   parameter int CORE     = 16,
   parameter int IMGSIZE  = 12,
   parameter int NETSIZE  = 14
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req,
   input  logic [LWIDTH-1:0]        total_out,
   input  logic [LWIDTH-1:0]        total_in,
   input  logic [IMGSIZE-1:0]       input_addr,
   input  logic [IMGSIZE-1:0]       output_addr,
   output logic                     ack,
   output logic                     mem_img_we,
   output logic [IMGSIZE-1:0]       mem_img_addr,
   output logic [DWIDTH-1:0]        write_mem_img,
   input  logic [DWIDTH-1:0]        read_img,
   output logic [NETSIZE-1:0]       mem_net_addr,
   input  logic [CORE*DWIDTH-1:0]   read_net
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_MAC   = 3'd1;
   localparam logic [2:0] S_BIAS  = 3'd2;
   localparam logic [2:0] S_FLUSH = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [1:0] K_NONE = 2'd0;
   localparam logic [1:0] K_MAC  = 2'd1;
   localparam logic [1:0] K_BIAS = 2'd2;

   localparam int LANE_W = (CORE > 1) ? $clog2(CORE) : 1;
   localparam logic signed [ACCWIDTH-1:0] HALF    = {{(ACCWIDTH-1){1'b0}}, 1'b1} <<< (FRAC-1);
   localparam logic signed [ACCWIDTH-1:0] SAT_MAX = {{(ACCWIDTH-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
   localparam logic signed [ACCWIDTH-1:0] SAT_MIN = {{(ACCWIDTH-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

   logic [2:0]               state_q, state_d;
   logic [LWIDTH-1:0]        cnt_q, cnt_d;
   logic [LWIDTH-1:0]        tin_q, tin_d;
   logic [LWIDTH-1:0]        rem_q, rem_d;
   logic [IMGSIZE-1:0]       in_addr_q, in_addr_d;
   logic [IMGSIZE-1:0]       out_addr_q, out_addr_d;
   logic [IMGSIZE-1:0]       blk_off_q, blk_off_d;
   logic [NETSIZE-1:0]       base_q, base_d;
   logic [1:0]               kind1_q;
   logic                     vld2_q;
   logic signed [ACCWIDTH-1:0] prod_q [CORE];
   logic signed [ACCWIDTH-1:0] acc_q  [CORE];

   logic              last_blk, wr_last, acc_clr;
   logic [LWIDTH-1:0] n_b;
   logic [1:0]        issue_kind;

   function automatic logic signed [ACCWIDTH-1:0] mul_term(input logic [DWIDTH-1:0] x,
                                                           input logic [DWIDTH-1:0] w);
      logic signed [2*DWIDTH-1:0] p;
      p = $signed(x) * $signed(w);
      return ACCWIDTH'(p);
   endfunction

   // Bias is pre-aligned to the product scale and carries the rounding half-LSB.
   function automatic logic signed [ACCWIDTH-1:0] bias_term(input logic [DWIDTH-1:0] b);
      return (ACCWIDTH'($signed(b)) <<< FRAC) + HALF;
   endfunction

   function automatic logic [DWIDTH-1:0] finish_lane(input logic signed [ACCWIDTH-1:0] a);
      logic signed [ACCWIDTH-1:0] s;
      logic [DWIDTH-1:0]          r;
      s = a >>> FRAC;
      if (s > SAT_MAX)      r = SAT_MAX[DWIDTH-1:0];
      else if (s < SAT_MIN) r = SAT_MIN[DWIDTH-1:0];
      else                  r = s[DWIDTH-1:0];
`ifdef GOBOU_RELU_EN
      if (r[DWIDTH-1]) r = '0;
`endif
      return r;
   endfunction

   assign last_blk   = (rem_q <= LWIDTH'(CORE));
   assign n_b        = last_blk ? rem_q : LWIDTH'(CORE);
   assign wr_last    = (cnt_q == n_b - LWIDTH'(1));
   assign acc_clr    = (state_q == S_IDLE) || (state_q == S_WRITE && wr_last);
   assign issue_kind = (state_q == S_MAC)  ? K_MAC :
                       (state_q == S_BIAS) ? K_BIAS : K_NONE;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tin_d      = tin_q;
      rem_d      = rem_q;
      in_addr_d  = in_addr_q;
      out_addr_d = out_addr_q;
      blk_off_d  = blk_off_q;
      base_d     = base_q;
      case (state_q)
         S_IDLE: if (req) begin
            tin_d      = total_in;
            rem_d      = total_out;
            in_addr_d  = input_addr;
            out_addr_d = output_addr;
            blk_off_d  = '0;
            base_d     = '0;
            cnt_d      = '0;
            if (total_out == '0)     state_d = S_DONE;
            else if (total_in == '0) state_d = S_BIAS;
            else                     state_d = S_MAC;
         end
         S_MAC: begin
            cnt_d = cnt_q + LWIDTH'(1);
            if (cnt_q == tin_q - LWIDTH'(1)) state_d = S_BIAS;
         end
         S_BIAS: begin
            cnt_d   = '0;
            state_d = S_FLUSH;
         end
         S_FLUSH: begin
            cnt_d = cnt_q + LWIDTH'(1);
            if (cnt_q == LWIDTH'(1)) begin
               cnt_d   = '0;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            cnt_d = cnt_q + LWIDTH'(1);
            if (wr_last) begin
               cnt_d = '0;
               if (last_blk) state_d = S_DONE;
               else begin
                  rem_d     = rem_q - LWIDTH'(CORE);
                  blk_off_d = blk_off_q + IMGSIZE'(CORE);
                  base_d    = base_q + NETSIZE'(tin_q) + NETSIZE'(1);
                  state_d   = (tin_q == '0) ? S_BIAS : S_MAC;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         tin_q      <= '0;
         rem_q      <= '0;
         in_addr_q  <= '0;
         out_addr_q <= '0;
         blk_off_q  <= '0;
         base_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tin_q      <= tin_d;
         rem_q      <= rem_d;
         in_addr_q  <= in_addr_d;
         out_addr_q <= out_addr_d;
         blk_off_q  <= blk_off_d;
         base_q     <= base_d;
      end
   end

   // Two-stage lane pipeline: memory data -> product/bias term -> accumulate.
   // NOTE: the lane register arrays are reset explicitly; they are flops, not a RAM, so this is cheap.
   always_ff @(posedge clk) begin
      if (rst) begin
         kind1_q <= K_NONE;
         vld2_q  <= 1'b0;
         for (int k = 0; k < CORE; k++) begin
            prod_q[k] <= '0;
            acc_q[k]  <= '0;
         end
      end else begin
         kind1_q <= issue_kind;
         vld2_q  <= (kind1_q != K_NONE);
         for (int k = 0; k < CORE; k++) begin
            case (kind1_q)
               K_MAC:   prod_q[k] <= mul_term(read_img, read_net[k*DWIDTH +: DWIDTH]);
               K_BIAS:  prod_q[k] <= bias_term(read_net[k*DWIDTH +: DWIDTH]);
               default: prod_q[k] <= '0;
            endcase
            if (acc_clr)     acc_q[k] <= '0;
            else if (vld2_q) acc_q[k] <= acc_q[k] + prod_q[k];
         end
      end
   end

   assign ack        = (state_q == S_IDLE);
   assign mem_img_we = (state_q == S_WRITE);

   always_comb begin
      mem_img_addr  = '0;
      mem_net_addr  = '0;
      write_mem_img = '0;
      case (state_q)
         S_MAC: begin
            mem_img_addr = in_addr_q + IMGSIZE'(cnt_q);
            mem_net_addr = base_q + NETSIZE'(cnt_q);
         end
         S_BIAS:  mem_net_addr = base_q + NETSIZE'(tin_q);
         S_WRITE: begin
            mem_img_addr  = out_addr_q + blk_off_q + IMGSIZE'(cnt_q);
            write_mem_img = finish_lane(acc_q[cnt_q[LANE_W-1:0]]);
         end
         default: ;
      endcase
   end

endmodule
